// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start, data, optional even parity, stop.
// Start bit is on the line right after the accepting edge; tx_valid is ignored while a frame is in flight.
module serial_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 async_reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // The line value for the coming cycle is decided here so tx_out is a pure register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = ^tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          out_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          out_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              out_d   = par_q;
            end else begin
              state_d = STOP;
              out_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign tx_out   = out_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 clocks/bit without parity, 1 clock/bit with parity)
// checked every cycle against a frame-timing model, plus literal line sequences.
module tb_serial_tx;

  logic            clk = 1'b0;
  logic            async_reset;
  logic [1:0]      v;
  logic [1:0][7:0] dat;
  logic [1:0]      rdy, line, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit       m_act  [2];
  bit       m_done [2];
  int       m_k    [2];
  logic [7:0] m_w  [2];

  always #5 clk = ~clk;

  serial_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  serial_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut1 (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  function automatic int cpb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int pen(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int nfr(input int d);
    return 10 + pen(d);
  endfunction

  // Line bit j of a frame: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic line_bit(input logic [7:0] w, input int j, input int pe);
    if (j == 0) return 1'b0;
    if (j <= 8) return w[j-1];
    if (pe != 0 && j == 9) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update the model at the edge, compare both DUTs at the falling edge.
  task automatic tick();
    bit   was_idle;
    logic el;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (async_reset) begin
        m_act[d]  = 1'b0;
        m_done[d] = 1'b0;
      end else begin
        was_idle  = !m_act[d];
        m_done[d] = 1'b0;
        if (m_act[d] && (cyc - m_k[d]) == nfr(d) * cpb(d)) begin
          m_act[d]  = 1'b0;
          m_done[d] = 1'b1;
        end
        if (was_idle && v[d]) begin
          m_act[d] = 1'b1;
          m_k[d]   = cyc;
          m_w[d]   = dat[d];
        end
      end
    end
    @(negedge clk);
    if (!async_reset) begin
      for (int d = 0; d < 2; d++) begin
        el = m_act[d] ? line_bit(m_w[d], (cyc - m_k[d]) / cpb(d), pen(d)) : 1'b1;
        chk($sformatf("d%0d tx_out", d), line[d], el);
        chk($sformatf("d%0d tx_ready", d), rdy[d], !m_act[d]);
        chk($sformatf("d%0d tx_busy", d), busy[d], m_act[d]);
        chk($sformatf("d%0d tx_done", d), done[d], m_done[d]);
      end
    end
  endtask

  // Send one word and check the line against a literal bit sequence (seq[j] = line bit j).
  task automatic send_seq(input int d, input logic [7:0] w, input logic [10:0] seq);
    int c;
    int n;
    c = cpb(d);
    n = nfr(d);
    v[d]   = 1'b1;
    dat[d] = w;
    tick();
    v[d]   = 1'b0;
    dat[d] = ~w;
    for (int t = 0; t < n * c; t++) begin
      if (t > 0) tick();
      if (t % c == 0) chk($sformatf("d%0d seq %0h bit %0d", d, w, t / c), line[d], seq[t / c]);
      chk($sformatf("d%0d seq %0h done early", d, w), done[d], 0);
    end
    tick();
    chk($sformatf("d%0d seq %0h done pulse", d, w), done[d], 1);
    chk($sformatf("d%0d seq %0h done line", d, w), line[d], 1);
    tick();
    chk($sformatf("d%0d seq %0h done width", d, w), done[d], 0);
  endtask

  initial begin
    async_reset = 1'b1;
    v   = '0;
    dat = '0;
    tick();
    tick();
    async_reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset tx_out", line[d], 1);
      chk("reset tx_ready", rdy[d], 1);
      chk("reset tx_busy", busy[d], 0);
      chk("reset tx_done", done[d], 0);
    end

    send_seq(0, 8'hA5, 11'b01101001010);
    send_seq(1, 8'h07, 11'b11000001110);
    send_seq(1, 8'h03, 11'b10000000110);

    // Back-to-back with tx_valid held high.
    v[0]   = 1'b1;
    dat[0] = 8'h0F;
    tick();
    dat[0] = 8'hF0;
    repeat (39) tick();
    chk("b2b done before end", done[0], 0);
    tick();
    chk("b2b done", done[0], 1);
    chk("b2b idle line", line[0], 1);
    chk("b2b ready", rdy[0], 1);
    tick();
    chk("b2b second start", line[0], 0);
    chk("b2b second busy", busy[0], 1);
    v[0] = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 4)  chk("b2b F0 bit0", line[0], 0);
      if (t == 20) chk("b2b F0 bit4", line[0], 1);
      if (t == 40) chk("b2b second done", done[0], 1);
    end
    tick();

    // Inputs while busy are ignored.
    v[0]   = 1'b1;
    dat[0] = 8'h96;
    tick();
    v[0]   = 1'b0;
    dat[0] = 8'h00;
    repeat (8) tick();
    v[0]   = 1'b1;
    dat[0] = 8'h55;
    tick();
    v[0]   = 1'b0;
    dat[0] = 8'hAA;
    repeat (2) tick();
    chk("busy 96 bit1", line[0], 1);
    repeat (28) tick();
    chk("busy 96 parity-free stop", line[0], 1);
    tick();
    chk("busy frame done", done[0], 1);
    repeat (6) begin
      tick();
      chk("no second frame busy", busy[0], 0);
      chk("no second frame line", line[0], 1);
    end

    // Abort during data bit 3 with a reset between edges.
    v[0]   = 1'b1;
    dat[0] = 8'hC3;
    tick();
    v[0] = 1'b0;
    repeat (17) tick();
    chk("abort data bit3 low", line[0], 0);
    #2 async_reset = 1'b1;
    #1;
    chk("abort tx_out", line[0], 1);
    chk("abort tx_ready", rdy[0], 1);
    chk("abort tx_busy", busy[0], 0);
    chk("abort tx_done", done[0], 0);
    tick();
    tick();
    async_reset = 1'b0;
    repeat (40) begin
      tick();
      chk("no done after abort", done[0], 0);
    end
    send_seq(0, 8'h3C, 11'b01001111000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
